// File: rtl/sap_1_microprogram_sequencer.sv
// SAP-1 microprogram sequencer: walks the control-ROM address through the shared fetch
// routine, jumps to the mapped execute routine, and drives the one-hot T-state ring.
module sap_1_microprogram_sequencer #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] FETCH_START = 8'h00,
  parameter int                    FETCH_LEN   = 3,
  parameter int                    MAX_TSTATES = 6
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   En,
  input  logic [ADDR_WIDTH-1:0]  map_addr,
  input  logic                   map_valid,
  input  logic                   uend,
  input  logic                   uhalt,
  output logic [ADDR_WIDTH-1:0]  uaddr,
  output logic [MAX_TSTATES-1:0] t_state,
  output logic [1:0]             phase,
  output logic                   halted,
  output logic                   illegal
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_HALT  = 2'b10
  } state_t;

  localparam logic [MAX_TSTATES-1:0] T1 = MAX_TSTATES'(1);

  state_t                 r_state,   w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_uaddr,   w_uaddr_nxt;
  logic [MAX_TSTATES-1:0] r_tstate,  w_tstate_nxt;
  logic                   r_illegal, w_illegal_nxt;

  logic [MAX_TSTATES-1:0] w_tstate_rot;
  logic                   w_fetch_last;
  logic                   w_ring_last;

  assign w_tstate_rot = {r_tstate[MAX_TSTATES-2:0], r_tstate[MAX_TSTATES-1]};
  assign w_fetch_last = r_tstate[FETCH_LEN-1];
  assign w_ring_last  = r_tstate[MAX_TSTATES-1];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state   <= S_FETCH;
      r_uaddr   <= FETCH_START;
      r_tstate  <= T1;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_uaddr   <= w_uaddr_nxt;
      r_tstate  <= w_tstate_nxt;
      r_illegal <= w_illegal_nxt;
    end
  end

  // Each branch either loads map_addr, increments, or restarts fetch -- never two at once.
  always_comb begin
    w_state_nxt   = r_state;
    w_uaddr_nxt   = r_uaddr;
    w_tstate_nxt  = r_tstate;
    w_illegal_nxt = 1'b0;
    if (En) begin
      case (r_state)
        S_FETCH: begin
          if (!w_fetch_last) begin
            w_uaddr_nxt  = r_uaddr + ADDR_WIDTH'(1);
            w_tstate_nxt = w_tstate_rot;
          end else if (map_valid) begin
            w_uaddr_nxt  = map_addr;
            w_tstate_nxt = w_tstate_rot;
            w_state_nxt  = S_EXEC;
          end else begin
            w_illegal_nxt = 1'b1;
            w_uaddr_nxt   = FETCH_START;
            w_tstate_nxt  = T1;
          end
        end
        S_EXEC: begin
          if (uhalt) begin
            w_state_nxt = S_HALT;
          end else if (uend || w_ring_last) begin
            w_uaddr_nxt  = FETCH_START;
            w_tstate_nxt = T1;
            w_state_nxt  = S_FETCH;
          end else begin
            w_uaddr_nxt  = r_uaddr + ADDR_WIDTH'(1);
            w_tstate_nxt = w_tstate_rot;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  assign uaddr   = r_uaddr;
  assign t_state = r_tstate;
  assign phase   = r_state;
  assign halted  = (r_state == S_HALT);
  assign illegal = r_illegal;

endmodule

// File: tb/tb_sap_1_microprogram_sequencer.sv
// Scoreboard bench for sap_1_microprogram_sequencer: expected output vectors are queued as
// each cycle is driven and compared against the captured outputs at the end of each scenario.
module tb_sap_1_microprogram_sequencer;

  localparam logic [1:0] PF = 2'b00;
  localparam logic [1:0] PE = 2'b01;
  localparam logic [1:0] PH = 2'b10;

  logic       Clk;
  logic       Reset_n;
  logic       En;
  logic [7:0] map_addr;
  logic       map_valid;
  logic       uend;
  logic       uhalt;
  logic [7:0] uaddr;
  logic [5:0] t_state;
  logic [1:0] phase;
  logic       halted;
  logic       illegal;

  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];
  int n_cmp;
  int n_err;

  sap_1_microprogram_sequencer #(
    .ADDR_WIDTH (8),
    .FETCH_START(8'h00),
    .FETCH_LEN  (3),
    .MAX_TSTATES(6)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .En       (En),
    .map_addr (map_addr),
    .map_valid(map_valid),
    .uend     (uend),
    .uhalt    (uhalt),
    .uaddr    (uaddr),
    .t_state  (t_state),
    .phase    (phase),
    .halted   (halted),
    .illegal  (illegal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [18:0] pk(input logic [7:0] a, input logic [5:0] t,
                                     input logic [1:0] p, input logic h, input logic i);
    return {a, t, p, h, i};
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge outputs, capture the actual ones.
  task automatic cyc(input logic rn, input logic en, input logic mv, input logic [7:0] ma,
                     input logic ue, input logic uh, input logic [18:0] e);
    @(negedge Clk);
    Reset_n   = rn;
    En        = en;
    map_valid = mv;
    map_addr  = ma;
    uend      = ue;
    uhalt     = uh;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    obs_q.push_back({uaddr, t_state, phase, halted, illegal});
  endtask

  task automatic test_reset();
    logic [18:0] e, o;
    int idx;
    cyc(0, 1, 1, 8'h10, 0, 0, pk(8'h00, 6'h01, PF, 0, 0));
    cyc(0, 0, 0, 8'h77, 1, 1, pk(8'h00, 6'h01, PF, 0, 0));
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset[%0d]: got %h expected %h (uaddr,t_state,phase,halted,illegal)", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_normal();
    logic [18:0] e, o;
    int idx;
    cyc(0, 1, 1, 8'h10, 0, 0, pk(8'h00, 6'h01, PF, 0, 0));
    cyc(1, 1, 1, 8'h10, 0, 0, pk(8'h01, 6'h02, PF, 0, 0));
    cyc(1, 1, 1, 8'h10, 0, 0, pk(8'h02, 6'h04, PF, 0, 0));
    cyc(1, 1, 1, 8'h10, 0, 0, pk(8'h10, 6'h08, PE, 0, 0));
    cyc(1, 1, 1, 8'h10, 0, 0, pk(8'h11, 6'h10, PE, 0, 0));
    cyc(1, 1, 1, 8'h10, 0, 0, pk(8'h12, 6'h20, PE, 0, 0));
    cyc(1, 1, 1, 8'h10, 0, 0, pk(8'h00, 6'h01, PF, 0, 0));
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL normal[%0d]: got %h expected %h (uaddr,t_state,phase,halted,illegal)", idx, o, e);
      end
      idx++;
    end
  endtask

  // uend/uhalt asserted during fetch must be ignored; uend in the first execute step ends early.
  task automatic test_uend();
    logic [18:0] e, o;
    int idx;
    cyc(0, 1, 1, 8'h10, 0, 0, pk(8'h00, 6'h01, PF, 0, 0));
    cyc(1, 1, 1, 8'h10, 1, 1, pk(8'h01, 6'h02, PF, 0, 0));
    cyc(1, 1, 1, 8'h10, 1, 0, pk(8'h02, 6'h04, PF, 0, 0));
    cyc(1, 1, 1, 8'h10, 1, 1, pk(8'h10, 6'h08, PE, 0, 0));
    cyc(1, 1, 1, 8'h10, 1, 0, pk(8'h00, 6'h01, PF, 0, 0));
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL uend[%0d]: got %h expected %h (uaddr,t_state,phase,halted,illegal)", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_illegal();
    logic [18:0] e, o;
    int idx;
    cyc(0, 1, 1, 8'h10, 0, 0, pk(8'h00, 6'h01, PF, 0, 0));
    cyc(1, 1, 0, 8'h55, 0, 0, pk(8'h01, 6'h02, PF, 0, 0));
    cyc(1, 1, 0, 8'h55, 0, 0, pk(8'h02, 6'h04, PF, 0, 0));
    cyc(1, 1, 0, 8'h55, 0, 0, pk(8'h00, 6'h01, PF, 0, 1));
    cyc(1, 1, 1, 8'h20, 0, 0, pk(8'h01, 6'h02, PF, 0, 0));
    cyc(1, 1, 1, 8'h20, 0, 0, pk(8'h02, 6'h04, PF, 0, 0));
    cyc(1, 1, 0, 8'h20, 0, 0, pk(8'h00, 6'h01, PF, 0, 1));
    cyc(1, 0, 0, 8'h20, 0, 0, pk(8'h00, 6'h01, PF, 0, 0));
    cyc(1, 1, 1, 8'h20, 0, 0, pk(8'h01, 6'h02, PF, 0, 0));
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL illegal[%0d]: got %h expected %h (uaddr,t_state,phase,halted,illegal)", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_wrap();
    logic [18:0] e, o;
    int idx;
    cyc(0, 1, 1, 8'hFE, 0, 0, pk(8'h00, 6'h01, PF, 0, 0));
    cyc(1, 1, 1, 8'hFE, 0, 0, pk(8'h01, 6'h02, PF, 0, 0));
    cyc(1, 1, 1, 8'hFE, 0, 0, pk(8'h02, 6'h04, PF, 0, 0));
    cyc(1, 1, 1, 8'hFE, 0, 0, pk(8'hFE, 6'h08, PE, 0, 0));
    cyc(1, 1, 1, 8'hFE, 0, 0, pk(8'hFF, 6'h10, PE, 0, 0));
    cyc(1, 1, 1, 8'hFE, 0, 0, pk(8'h00, 6'h20, PE, 0, 0));
    cyc(1, 1, 1, 8'hFE, 0, 0, pk(8'h00, 6'h01, PF, 0, 0));
    cyc(1, 1, 1, 8'hFE, 0, 0, pk(8'h01, 6'h02, PF, 0, 0));
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL wrap[%0d]: got %h expected %h (uaddr,t_state,phase,halted,illegal)", idx, o, e);
      end
      idx++;
    end
  endtask

  // uhalt wins over uend; afterwards random input activity must not disturb HALT.
  task automatic test_halt();
    logic [18:0] e, o;
    int idx;
    cyc(0, 1, 1, 8'h30, 0, 0, pk(8'h00, 6'h01, PF, 0, 0));
    cyc(1, 1, 1, 8'h30, 0, 0, pk(8'h01, 6'h02, PF, 0, 0));
    cyc(1, 1, 1, 8'h30, 0, 0, pk(8'h02, 6'h04, PF, 0, 0));
    cyc(1, 1, 1, 8'h30, 0, 0, pk(8'h30, 6'h08, PE, 0, 0));
    cyc(1, 1, 1, 8'h30, 1, 1, pk(8'h30, 6'h08, PH, 1, 0));
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pk(8'h30, 6'h08, PH, 1, 0));
    end
    cyc(0, 1'($urandom_range(0, 1)), 1, 8'h30, 0, 1, pk(8'h00, 6'h01, PF, 0, 0));
    cyc(1, 1, 1, 8'h30, 0, 0, pk(8'h01, 6'h02, PF, 0, 0));
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL halt[%0d]: got %h expected %h (uaddr,t_state,phase,halted,illegal)", idx, o, e);
      end
      idx++;
    end
  endtask

  task automatic test_enable_hold();
    logic [18:0] e, o;
    int idx;
    cyc(0, 1, 1, 8'h40, 0, 0, pk(8'h00, 6'h01, PF, 0, 0));
    cyc(1, 1, 1, 8'h40, 0, 0, pk(8'h01, 6'h02, PF, 0, 0));
    cyc(1, 1, 1, 8'h40, 0, 0, pk(8'h02, 6'h04, PF, 0, 0));
    cyc(1, 1, 1, 8'h40, 0, 0, pk(8'h40, 6'h08, PE, 0, 0));
    cyc(1, 1, 1, 8'h40, 0, 0, pk(8'h41, 6'h10, PE, 0, 0));
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, i[0], 8'h99, 1, i[1], pk(8'h41, 6'h10, PE, 0, 0));
    end
    cyc(0, 0, 1, 8'h40, 0, 0, pk(8'h00, 6'h01, PF, 0, 0));
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL en_hold[%0d]: got %h expected %h (uaddr,t_state,phase,halted,illegal)", idx, o, e);
      end
      idx++;
    end
  endtask

  // Two consecutive instructions with different execute lengths and a reset mid-execute.
  task automatic test_back_to_back();
    logic [18:0] e, o;
    int idx;
    cyc(0, 1, 1, 8'h20, 0, 0, pk(8'h00, 6'h01, PF, 0, 0));
    cyc(1, 1, 1, 8'h20, 0, 0, pk(8'h01, 6'h02, PF, 0, 0));
    cyc(1, 1, 1, 8'h20, 0, 0, pk(8'h02, 6'h04, PF, 0, 0));
    cyc(1, 1, 1, 8'h20, 0, 0, pk(8'h20, 6'h08, PE, 0, 0));
    cyc(1, 1, 1, 8'h20, 0, 0, pk(8'h21, 6'h10, PE, 0, 0));
    cyc(1, 1, 1, 8'h20, 1, 0, pk(8'h00, 6'h01, PF, 0, 0));
    cyc(1, 1, 1, 8'h80, 0, 0, pk(8'h01, 6'h02, PF, 0, 0));
    cyc(1, 1, 1, 8'h80, 0, 0, pk(8'h02, 6'h04, PF, 0, 0));
    cyc(1, 1, 1, 8'h80, 0, 0, pk(8'h80, 6'h08, PE, 0, 0));
    cyc(1, 1, 0, 8'h33, 0, 0, pk(8'h81, 6'h10, PE, 0, 0));
    cyc(0, 1, 1, 8'h33, 0, 0, pk(8'h00, 6'h01, PF, 0, 0));
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL b2b[%0d]: got %h expected %h (uaddr,t_state,phase,halted,illegal)", idx, o, e);
      end
      idx++;
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    Reset_n   = 1'b0;
    En        = 1'b0;
    map_addr  = 8'h00;
    map_valid = 1'b0;
    uend      = 1'b0;
    uhalt     = 1'b0;
    test_reset();
    test_normal();
    test_uend();
    test_illegal();
    test_wrap();
    test_halt();
    test_enable_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
